dma_line_bridge: RTL
====================

# dma_line_bridge

Parametrised bridge between the host DMA cache-line FIFOs and the word-wide local memory controller port.
- **Load phase:** unpacks `size` cache lines from the DMA read FIFO into consecutive memory words starting at `base_addr`, then pulses `rd_done` to start the CPU.
- **Writeback phase:** on `wb_start` (CPU halt), reads the same region back, packs words into cache lines and pushes them to the DMA write FIFO.
- Sits in the AFU between the DMA interface and the memory controller's DMA port. Generalises line width, word width and memory address width, and adds a base address, a size-0 path and a gated writeback phase.

## Interface
- `CL_WIDTH`, 512, cache-line width in bits
- `WORD_WIDTH`, 32, memory word width; `CL_WIDTH % WORD_WIDTH == 0`; `WPL = CL_WIDTH/WORD_WIDTH >= 2`
- `SIZE_WIDTH`, 43, width of line count
- `MEM_ADDR_WIDTH`, 28, memory word-address width
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `go` in 1: start pulse; sampled only in IDLE
- `size` in SIZE_WIDTH: cache lines to transfer; latched on accepted `go`
- `base_addr` in MEM_ADDR_WIDTH: first word address; latched on accepted `go`
- `rd_empty` in 1: DMA read FIFO empty; `rd_data` is valid (show-ahead) while low
- `rd_data` in CL_WIDTH: DMA read line
- `rd_en` out 1: pop DMA read FIFO
- `wr_full` in 1: DMA write FIFO full
- `wr_data` out CL_WIDTH: line to host
- `wr_en` out 1: push DMA write FIFO
- `mem_en` out 1: memory request
- `mem_wr_en` out 1: 1 = write, 0 = read
- `mem_addr` out MEM_ADDR_WIDTH: word address
- `mem_wdata` out WORD_WIDTH: write data
- `mem_rdata` in WORD_WIDTH: read data, valid with `mem_valid`
- `mem_valid` in 1: request completes this cycle
- `rd_done` out 1: one-cycle pulse, load phase complete
- `wb_start` in 1: level; writeback may begin
- `busy` out 1: high in every state except IDLE
- `done` out 1: high from transfer completion until the next accepted `go`

## Operation
- States: IDLE, RD_POP, RD_STORE, HOLD, WB_LOAD, WB_PUSH.
- **IDLE:** on `go`, latch `size` and `base_addr`, clear `done`, clear line/word counters.
  - size != 0: go to RD_POP.
  - size == 0: pulse `rd_done`, set `done`, stay IDLE; no FIFO or memory activity.
- **RD_POP:** when `!rd_empty`, assert `rd_en` for one cycle, latch `rd_data` into the line register, go to RD_STORE.
- **RD_STORE:** issue WPL writes; word k = line bits `[k*WORD_WIDTH +: WORD_WIDTH]`.
  - Address = `base_addr + line*WPL + k`, modulo 2^MEM_ADDR_WIDTH (wraps silently).
  - Each request holds `mem_en`/`mem_wr_en`/`mem_addr`/`mem_wdata` stable until `mem_valid`, and retires in that cycle.
  - After the last word: go to RD_POP if lines remain; otherwise pulse `rd_done`, go to HOLD.
- **HOLD:** wait for `wb_start == 1`, then reset counters and go to WB_LOAD. `wb_start` is ignored in all other states.
- **WB_LOAD:** issue WPL reads at the same addresses; `mem_rdata` on `mem_valid` fills word k of the line register. After word WPL-1, go to WB_PUSH.
- **WB_PUSH:** when `!wr_full`, assert `wr_en` for one cycle with `wr_data` = line register.
  - If lines remain: go to WB_LOAD.
  - Else: set `done`, go to IDLE.
- `go` outside IDLE is ignored.
- `rd_en` is asserted only when `!rd_empty`; `wr_en` is asserted only when `!wr_full`.
- Reset mid-operation: return to IDLE immediately, clear counters and the line register, deassert all outputs. Partial lines are discarded.

## Timing
- Reset values: all outputs 0; `busy = 0`, `done = 0`, `rd_done = 0`, `wr_data = 0`, `mem_addr = 0`.
- All outputs are registered except `rd_en`/`wr_en`, which may combine state with `!rd_empty`/`!wr_full`.
- `busy` rises the cycle after an accepted `go`.
- With `mem_valid` returned in the request cycle:
  - Load: WPL+1 cycles per line.
  - Writeback: WPL+1 cycles per line with `wr_full` low.
- Back-to-back memory requests are allowed on consecutive cycles.
- `rd_done` pulses in the cycle after the final write retires. `done` rises in the cycle after the final `wr_en`.
- `rd_empty` or `wr_full` held high stalls the FSM indefinitely; no timeout.

## Configuration
- `DMA_BRIDGE_BYTE_SWAP_EN`:
  - Defined: each word is byte-reversed on unpack (line→memory) and on pack (memory→line); requires `WORD_WIDTH % 8 == 0`.
  - Undefined: words pass unchanged.
  - Latency is identical in both builds.

## Test plan
- Defaults, `size=1`, `base=0x100`, line = words 0..15 with values 0x0..0xF, `mem_valid` tied high → writes to 0x100..0x10F with data 0x0..0xF; `rd_done` pulses 18 cycles after `go`; `wb_start=1` → one `wr_en` carrying the identical line; `done=1`.
- `size=3`, `rd_empty` high for 5 cycles before each line, `mem_valid` delayed 2 cycles per request → 48 writes to addresses base..base+47 in order; no `rd_en` while `rd_empty` is high.
- `size=2`, `wr_full` high for 10 cycles during WB_PUSH → `wr_en` is held off and fires once `wr_full` drops; 2 lines written back; `done` rises after the 2nd push.
- `size=0` → `rd_done` pulses one cycle and `done=1`; `mem_en`, `rd_en`, `wr_en` stay 0.
- `base=0xFFFFFF8`, `size=1` → addresses 0xFFFFFF8..0xFFFFFFF, then 0x0000000..0x0000007.
- `rst_n` low mid-RD_STORE (word 7) → all outputs 0 immediately; a new `go` with `size=1` completes normally. With `DMA_BRIDGE_BYTE_SWAP_EN` defined, word 0x11223344 is stored as 0x44332211.

Source files
------------

// File: rtl/dma_line_bridge.sv
// rtl/dma_line_bridge.sv - DMA cache-line FIFOs to word-wide memory port bridge (load + writeback).
// Optional build macro: DMA_BRIDGE_BYTE_SWAP_EN (byte-reverse each word on unpack and pack).
module dma_line_bridge #(
  parameter int CL_WIDTH       = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int SIZE_WIDTH     = 43,
  parameter int MEM_ADDR_WIDTH = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic [SIZE_WIDTH-1:0]     size,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic                      rd_empty,
  input  logic [CL_WIDTH-1:0]       rd_data,
  output logic                      rd_en,
  input  logic                      wr_full,
  output logic [CL_WIDTH-1:0]       wr_data,
  output logic                      wr_en,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_valid,
  output logic                      rd_done,
  input  logic                      wb_start,
  output logic                      busy,
  output logic                      done
);

  localparam int WPL  = CL_WIDTH / WORD_WIDTH;
  localparam int WIDX = $clog2(WPL);

  typedef enum logic [2:0] {IDLE, RD_POP, RD_STORE, HOLD, WB_LOAD, WB_PUSH} state_t;

  state_t                    state;
  logic [SIZE_WIDTH-1:0]     size_q;
  logic [SIZE_WIDTH-1:0]     lines_left;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [WIDX-1:0]           word_idx;
  logic [CL_WIDTH-1:0]       line_q;
  logic                      last_word;
  logic                      last_line;

  function automatic logic [WORD_WIDTH-1:0] swap_word(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = w;
`ifdef DMA_BRIDGE_BYTE_SWAP_EN
    for (int b = 0; b < WORD_WIDTH / 8; b++) r[b*8 +: 8] = w[WORD_WIDTH-8-b*8 +: 8];
`endif
    return r;
  endfunction

  assign last_word = (word_idx == WIDX'(WPL - 1));
  assign last_line = (lines_left == SIZE_WIDTH'(1));
  assign rd_en     = (state == RD_POP) && !rd_empty;
  assign wr_en     = (state == WB_PUSH) && !wr_full;
  assign wr_data   = line_q;

  // addr_q always holds the address of the next request to issue; the region is
  // contiguous, so a running counter replaces base + line*WPL + k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= '0;
      lines_left <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      word_idx   <= '0;
      line_q     <= '0;
      mem_en     <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_done    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            size_q     <= size;
            base_q     <= base_addr;
            lines_left <= size;
            addr_q     <= base_addr;
            word_idx   <= '0;
            done       <= 1'b0;
            if (size == '0) begin
              rd_done <= 1'b1;
              done    <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= RD_POP;
            end
          end
        end
        RD_POP: begin
          if (!rd_empty) begin
            // word 0 goes straight out; the rest are shifted down one per retire
            line_q    <= rd_data >> WORD_WIDTH;
            mem_wdata <= swap_word(rd_data[WORD_WIDTH-1:0]);
            mem_en    <= 1'b1;
            mem_wr_en <= 1'b1;
            mem_addr  <= addr_q;
            addr_q    <= addr_q + MEM_ADDR_WIDTH'(1);
            word_idx  <= '0;
            state     <= RD_STORE;
          end
        end
        RD_STORE: begin
          if (mem_valid) begin
            if (last_word) begin
              mem_en     <= 1'b0;
              mem_wr_en  <= 1'b0;
              word_idx   <= '0;
              lines_left <= lines_left - SIZE_WIDTH'(1);
              if (last_line) begin
                rd_done <= 1'b1;
                state   <= HOLD;
              end else begin
                state <= RD_POP;
              end
            end else begin
              word_idx  <= word_idx + WIDX'(1);
              mem_addr  <= addr_q;
              addr_q    <= addr_q + MEM_ADDR_WIDTH'(1);
              mem_wdata <= swap_word(line_q[WORD_WIDTH-1:0]);
              line_q    <= line_q >> WORD_WIDTH;
            end
          end
        end
        HOLD: begin
          if (wb_start) begin
            lines_left <= size_q;
            word_idx   <= '0;
            mem_en     <= 1'b1;
            mem_wr_en  <= 1'b0;
            mem_addr   <= base_q;
            addr_q     <= base_q + MEM_ADDR_WIDTH'(1);
            state      <= WB_LOAD;
          end
        end
        WB_LOAD: begin
          if (mem_valid) begin
            // words enter at the top so word 0 ends up in the low bits
            line_q <= {swap_word(mem_rdata), line_q[CL_WIDTH-1:WORD_WIDTH]};
            if (last_word) begin
              mem_en   <= 1'b0;
              word_idx <= '0;
              state    <= WB_PUSH;
            end else begin
              word_idx <= word_idx + WIDX'(1);
              mem_addr <= addr_q;
              addr_q   <= addr_q + MEM_ADDR_WIDTH'(1);
            end
          end
        end
        WB_PUSH: begin
          if (!wr_full) begin
            lines_left <= lines_left - SIZE_WIDTH'(1);
            if (last_line) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              mem_en   <= 1'b1;
              mem_addr <= addr_q;
              addr_q   <= addr_q + MEM_ADDR_WIDTH'(1);
              state    <= WB_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
